arb_periferico: RTL and testbench

Two-requester arbiter sharing one PERIFERICO send/ack link between two CPU instances. Each CPU uses the existing four-phase send/ack protocol. The arbiter grants the link round-robin, latches the winner's data, and relays the handshake in both directions. It also counts completed transfers per requester. It sits between the CPUs and the single peripheral in the system top.

---
 rtl/arb_periferico_if.sv | 29 ++
 rtl/arb_periferico.sv | 128 ++++++++++++
 tb/tb_arb_periferico.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_periferico_if.sv
// Bundle of the CPU-side and peripheral-side send/ack signals around the
// two-requester PERIFERICO arbiter. The arbiter connects through 'slave';
// the environment (CPUs, peripheral, bench) drives through 'master'.
interface arb_periferico_if #(
  parameter int DATA_W = 4
);
  logic              cpu0_send;
  logic [DATA_W-1:0] cpu0_dados;
  logic              cpu0_ack;
  logic              cpu1_send;
  logic [DATA_W-1:0] cpu1_dados;
  logic              cpu1_ack;
  logic              per_send;
  logic [DATA_W-1:0] per_dados;
  logic              per_ack;
  logic [1:0]        arb_grant;
  logic [7:0]        cnt0;
  logic [7:0]        cnt1;

  modport slave (
    input  cpu0_send, cpu0_dados, cpu1_send, cpu1_dados, per_ack,
    output cpu0_ack, cpu1_ack, per_send, per_dados, arb_grant, cnt0, cnt1
  );

  modport master (
    output cpu0_send, cpu0_dados, cpu1_send, cpu1_dados, per_ack,
    input  cpu0_ack, cpu1_ack, per_send, per_dados, arb_grant, cnt0, cnt1
  );
endinterface

// File: rtl/arb_periferico.sv
// Round-robin arbiter sharing one PERIFERICO four-phase send/ack link
// between two CPUs. The winner's data is latched at grant time, the
// handshake is relayed in both directions with one register stage, and
// completed transfers are counted per requester. Every output is a flop.
module arb_periferico #(
  parameter int DATA_W = 4
) (
  input  logic            arb_clock,
  input  logic            arb_reset,
  arb_periferico_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_per_send;
  logic              w_per_send_nxt;
  logic [DATA_W-1:0] r_per_dados;
  logic [DATA_W-1:0] w_per_dados_nxt;
  logic [1:0]        r_ack;
  logic [1:0]        w_ack_nxt;
  logic [1:0]        r_grant;
  logic [1:0]        w_grant_nxt;
  logic              r_last;        // last served requester: 0=CPU0, 1=CPU1
  logic              w_last_nxt;
  logic [7:0]        r_cnt0;
  logic [7:0]        w_cnt0_nxt;
  logic [7:0]        r_cnt1;
  logic [7:0]        w_cnt1_nxt;

  logic [1:0]        w_req;
  logic              w_pick;        // requester chosen in IDLE
  logic              w_owner;       // requester owning the current transfer
  logic              w_owner_send;

  assign w_req        = {bus.cpu1_send, bus.cpu0_send};
  // With both requesting, the one not served last wins; otherwise the lone requester.
  assign w_pick       = (w_req == 2'b11) ? ~r_last : w_req[1];
  assign w_owner      = r_grant[1];
  assign w_owner_send = w_owner ? bus.cpu1_send : bus.cpu0_send;

  // Next-state and next-output decode for the grant/relay sequence.
  always_comb begin
    // NOTE: every target gets its hold value first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_per_send_nxt  = r_per_send;
    w_per_dados_nxt = r_per_dados;
    w_ack_nxt       = r_ack;
    w_grant_nxt     = r_grant;
    w_last_nxt      = r_last;
    w_cnt0_nxt      = r_cnt0;
    w_cnt1_nxt      = r_cnt1;

    unique case (r_state)
      IDLE: begin
        if (w_req != 2'b00) begin
          w_grant_nxt     = w_pick ? 2'b10 : 2'b01;
          w_per_dados_nxt = w_pick ? bus.cpu1_dados : bus.cpu0_dados;
          w_per_send_nxt  = 1'b1;
          w_state_nxt     = FWD;
        end
      end
      FWD: begin
        if (bus.per_ack) begin
          // The grant vector is one-hot, so it is exactly the ack to raise.
          w_ack_nxt   = r_grant;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!w_owner_send) begin
          w_per_send_nxt = 1'b0;
          w_state_nxt    = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.per_ack) begin
          w_ack_nxt   = 2'b00;
          w_grant_nxt = 2'b00;
          w_last_nxt  = w_owner;
          if (w_owner) w_cnt1_nxt = r_cnt1 + 8'd1;
          else         w_cnt0_nxt = r_cnt0 + 8'd1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge arb_clock) begin
    if (!arb_reset) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      r_state     <= IDLE;
      r_per_send  <= 1'b0;
      r_per_dados <= '0;
      r_ack       <= 2'b00;
      r_grant     <= 2'b00;
      r_last      <= 1'b1;
      r_cnt0      <= 8'd0;
      r_cnt1      <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_per_send  <= w_per_send_nxt;
      r_per_dados <= w_per_dados_nxt;
      r_ack       <= w_ack_nxt;
      r_grant     <= w_grant_nxt;
      r_last      <= w_last_nxt;
      r_cnt0      <= w_cnt0_nxt;
      r_cnt1      <= w_cnt1_nxt;
    end
  end

  assign bus.per_send  = r_per_send;
  assign bus.per_dados = r_per_dados;
  assign bus.cpu0_ack  = r_ack[0];
  assign bus.cpu1_ack  = r_ack[1];
  assign bus.arb_grant = r_grant;
  assign bus.cnt0      = r_cnt0;
  assign bus.cnt1      = r_cnt1;

endmodule

// File: tb/tb_arb_periferico.sv
// Bench for arb_periferico: CPU drivers and a peripheral responder drive
// random traffic; a transaction-level reference model pushes expected grants
// and completions into queues that a negedge monitor pops and compares.
module tb_arb_periferico;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arb_periferico_if #(.DATA_W(DW)) bus ();

  arb_periferico #(.DATA_W(DW)) dut (
    .arb_clock (clk),
    .arb_reset (rst_n),
    .bus       (bus.slave)
  );

  logic          tb_send  [2];
  logic [DW-1:0] tb_dados [2];
  logic          tb_per_ack;

  assign bus.cpu0_send  = tb_send[0];
  assign bus.cpu0_dados = tb_dados[0];
  assign bus.cpu1_send  = tb_send[1];
  assign bus.cpu1_dados = tb_dados[1];
  assign bus.per_ack    = tb_per_ack;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int owner; int data; } xfer_t;
  xfer_t grant_q [$];
  xfer_t done_q  [$];

  int            m_stage = 0;   // 0 free, 1 awaiting peripheral ack, 2 awaiting CPU release, 3 awaiting ack drop
  int            m_owner = 0;
  int            m_last  = 1;
  int            m_cnt [2] = '{0, 0};
  logic          m_exp_send  = 1'b0;
  logic [1:0]    m_exp_ack   = 2'b00;
  logic [1:0]    m_exp_grant = 2'b00;
  logic [DW-1:0] m_exp_data  = '0;
  bit            m_rst_edge  = 1'b1;

  initial forever begin
    @(posedge clk);
    m_rst_edge = !rst_n;
    if (!rst_n) begin
      m_stage = 0; m_last = 1; m_cnt = '{0, 0};
      m_exp_send = 1'b0; m_exp_ack = 2'b00; m_exp_grant = 2'b00; m_exp_data = '0;
      grant_q.delete(); done_q.delete();
    end else begin
      case (m_stage)
        0: if (tb_send[0] || tb_send[1]) begin
             if (tb_send[0] && tb_send[1]) m_owner = 1 - m_last;
             else                          m_owner = tb_send[0] ? 0 : 1;
             m_exp_data  = tb_dados[m_owner];
             m_exp_send  = 1'b1;
             m_exp_grant = 2'b00;
             m_exp_grant[m_owner] = 1'b1;
             grant_q.push_back('{m_owner, int'(tb_dados[m_owner])});
             m_stage = 1;
           end
        1: if (tb_per_ack) begin
             m_exp_ack[m_owner] = 1'b1;
             m_stage = 2;
           end
        2: if (!tb_send[m_owner]) begin
             m_exp_send = 1'b0;
             m_stage = 3;
           end
        default: if (!tb_per_ack) begin
             m_exp_ack   = 2'b00;
             m_exp_grant = 2'b00;
             m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 256;
             m_last = m_owner;
             done_q.push_back('{m_owner, m_cnt[m_owner]});
             m_stage = 0;
           end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_send = 1'b0;
  logic [1:0] prev_ack  = 2'b00;

  initial forever begin
    logic [1:0] cur_ack;
    xfer_t      x;
    @(negedge clk);
    cur_ack = {bus.cpu1_ack, bus.cpu0_ack};
    check("per_send", bus.per_send, m_exp_send);
    check("cpu_ack", cur_ack, m_exp_ack);
    check("arb_grant", bus.arb_grant, m_exp_grant);
    check("per_dados_hold", bus.per_dados, m_exp_data);
    check("cnt0", bus.cnt0, m_cnt[0]);
    check("cnt1", bus.cnt1, m_cnt[1]);
    if (!m_rst_edge) begin
      if (bus.per_send && !prev_send) begin
        if (grant_q.size() == 0) fail("unexpected_grant");
        else begin
          x = grant_q.pop_front();
          check("grant_owner", bus.arb_grant, 32'(1 << x.owner));
          check("grant_data", bus.per_dados, x.data);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (prev_ack[i] && !cur_ack[i]) begin
          if (done_q.size() == 0) fail("unexpected_completion");
          else begin
            x = done_q.pop_front();
            check("done_owner", i, x.owner);
            check("done_cnt", (i == 0) ? bus.cnt0 : bus.cnt1, x.data);
          end
        end
      end
    end
    prev_send = bus.per_send;
    prev_ack  = cur_ack;
  end

  // ---------------- peripheral responder ----------------
  int ack_dly_min = 0;
  int ack_dly_max = 0;
  int ack_cnt     = 0;
  bit resp_armed  = 1'b0;

  initial forever begin
    @(posedge clk); #2;
    if (bus.per_send && !tb_per_ack) begin
      if (!resp_armed) begin
        ack_cnt    = $urandom_range(ack_dly_max, ack_dly_min);
        resp_armed = 1'b1;
      end
      if (ack_cnt == 0) begin
        tb_per_ack = 1'b1;
        resp_armed = 1'b0;
      end else ack_cnt--;
    end else if (!bus.per_send && tb_per_ack) begin
      tb_per_ack = 1'b0;
    end
  end

  // ---------------- CPU driver ----------------
  task automatic cpu_xfer(input int idx, input logic [DW-1:0] d,
                          input bit scramble, input logic [DW-1:0] new_d,
                          input bit early_drop);
    int t;
    @(posedge clk); #2;
    tb_send[idx]  = 1'b1;
    tb_dados[idx] = d;
    t = 0;
    while (!bus.arb_grant[idx] && t < 500) begin @(posedge clk); #2; t++; end
    if (t >= 500) begin fail("grant_timeout"); tb_send[idx] = 1'b0; return; end
    if (scramble)   tb_dados[idx] = new_d;
    if (early_drop) tb_send[idx]  = 1'b0;
    t = 0;
    while (!((idx == 0) ? bus.cpu0_ack : bus.cpu1_ack) && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) begin fail("ack_rise_timeout"); tb_send[idx] = 1'b0; return; end
    repeat ($urandom_range(2, 0)) begin @(posedge clk); #2; end
    tb_send[idx] = 1'b0;
    t = 0;
    while (((idx == 0) ? bus.cpu0_ack : bus.cpu1_ack) && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) fail("ack_fall_timeout");
  endtask

  task automatic cpu_stream(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      cpu_xfer(idx, DW'($urandom), ($urandom_range(3, 0) == 0), DW'($urandom),
               ($urandom_range(4, 0) == 0));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      tb_send[0] = 1'($urandom); tb_send[1] = 1'($urandom);
      tb_dados[0] = DW'($urandom); tb_dados[1] = DW'($urandom);
      tb_per_ack = 1'($urandom);
      @(posedge clk); #2;
    end
    tb_send[0] = 1'b0; tb_send[1] = 1'b0;
    tb_dados[0] = '0;  tb_dados[1] = '0;
    tb_per_ack = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    tb_send[0] = 1'b0; tb_send[1] = 1'b0;
    tb_dados[0] = '0;  tb_dados[1] = '0;
    tb_per_ack = 1'b0;

    // Reset with random inputs: every output must be zero.
    do_reset();
    check("rst_per_send", bus.per_send, 0);
    check("rst_per_dados", bus.per_dados, 0);
    check("rst_ack", {bus.cpu1_ack, bus.cpu0_ack}, 0);
    check("rst_grant", bus.arb_grant, 0);
    check("rst_cnt", {bus.cnt1, bus.cnt0}, 0);
    rst_n = 1'b1;

    // Single CPU0 transfer, peripheral acking a couple of cycles later.
    ack_dly_min = 1; ack_dly_max = 1;
    cpu_xfer(0, 4'hA, 1'b0, 4'h0, 1'b0);
    check("single_dados", bus.per_dados, 4'hA);
    check("single_cnt0", bus.cnt0, 1);
    check("single_cnt1", bus.cnt1, 0);

    // Contention from reset: CPU0 then CPU1, twice.
    ack_dly_min = 0; ack_dly_max = 0;
    do_reset();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fork
        cpu_xfer(0, 4'h3, 1'b0, 4'h0, 1'b0);
        cpu_xfer(1, 4'hC, 1'b0, 4'h0, 1'b0);
      join
    end
    check("cont_cnt0", bus.cnt0, 2);
    check("cont_cnt1", bus.cnt1, 2);
    check("cont_last_dados", bus.per_dados, 4'hC);

    // Data stability: CPU1 data changes while the transfer is in flight.
    ack_dly_min = 2; ack_dly_max = 2;
    cpu_xfer(1, 4'h5, 1'b1, 4'hF, 1'b0);
    check("stable_dados", bus.per_dados, 4'h5);

    // Send withdrawn during FWD still completes the transfer.
    cpu_xfer(0, 4'h6, 1'b0, 4'h0, 1'b1);
    check("early_drop_cnt0", bus.cnt0, 3);

    // Counter wrap on CPU0.
    ack_dly_min = 0; ack_dly_max = 0;
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 255; i++) cpu_xfer(0, DW'(i), 1'b0, 4'h0, 1'b0);
    check("wrap_cnt0_255", bus.cnt0, 255);
    cpu_xfer(0, 4'h1, 1'b0, 4'h0, 1'b0);
    check("wrap_cnt0_0", bus.cnt0, 0);
    check("wrap_cnt1", bus.cnt1, 0);

    // Reset asserted in HOLD, then both requesting: CPU0 must win.
    do_reset();
    rst_n = 1'b1;
    @(posedge clk); #2;
    tb_dados[0] = 4'h7; tb_send[0] = 1'b1;
    t = 0;
    while (!bus.cpu0_ack && t < 100) begin @(posedge clk); #2; t++; end
    if (t >= 100) fail("midrst_hold_timeout");
    rst_n = 1'b0;
    tb_dados[1] = 4'h9; tb_send[1] = 1'b1;
    @(posedge clk); #2;
    check("midrst_per_send", bus.per_send, 0);
    check("midrst_ack0", bus.cpu0_ack, 0);
    check("midrst_grant", bus.arb_grant, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("midrst_first_grant", bus.arb_grant, 2'b01);
    check("midrst_first_dados", bus.per_dados, 4'h7);
    fork
      cpu_xfer(0, 4'h7, 1'b0, 4'h0, 1'b0);
      cpu_xfer(1, 4'h9, 1'b0, 4'h0, 1'b0);
    join
    check("midrst_cnt", {bus.cnt1, bus.cnt0}, 16'h0101);

    // Random concurrent traffic with random peripheral latency.
    ack_dly_min = 0; ack_dly_max = 3;
    fork
      cpu_stream(0, 40);
      cpu_stream(1, 40);
    join

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("grant_q_drained", grant_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
